regfile_write_ctrl: RTL and testbench

Write-port controller for the 32 x 32-bit register file. It shares the file's single write port between two requesters, A (ALU writeback) and B (load writeback), using valid/ready handshakes and round-robin arbitration. It also runs a clear sequence that zeroes registers 1..31, one per cycle. Its registered outputs connect directly to the register file's enable, regnum and d inputs.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arb2.sv | 27 ++
 rtl/regfile_write_ctrl.sv | 101 ++++++++++
 tb/tb_regfile_write_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file write-port controller.
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int DATA_W   = 32;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is requester A, bit 1 is requester B.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);
    logic last_b_q, last_b_d;

    // On a tie the requester not served last wins; last_b_q resets to B so A takes the first tie.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_b_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        last_b_d = advance_i ? gnt_o[1] : last_b_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_b_q <= 1'b1;
        else         last_b_q <= last_b_d;
    end
endmodule

// File: rtl/regfile_write_ctrl.sv
// Shares the register-file write port between two requesters and runs a
// one-register-per-cycle clear sweep of registers 1..NUM_REGS-1.
//
// state | meaning
// ARB   | arbitrate A/B requests, one transfer per cycle
// CLEAR | write zero to register cnt each cycle, requesters stalled
module regfile_write_ctrl
    import regfile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_valid_i,
    input  logic [ADDR_W-1:0] a_regnum_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [ADDR_W-1:0] b_regnum_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    input  logic              clear_req_i,
    output logic              busy_o,
    output logic              wr_enable_o,
    output logic [ADDR_W-1:0] wr_regnum_o,
    output logic [DATA_W-1:0] wr_data_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_regnum_q, wr_regnum_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              arb_en;
    logic [1:0]        req;
    logic [1:0]        gnt;

    // Ready must stay low during reset even if a requester is already valid.
    assign arb_en = rst_ni && (state_q == ARB) && !clear_req_i;
    assign req    = arb_en ? {b_valid_i, a_valid_i} : 2'b00;

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req),
        .advance_i (|gnt),
        .gnt_o     (gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_regnum_d = wr_regnum_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            ARB: begin
                if (clear_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = ADDR_W'(1);
                end else if (gnt[0]) begin
                    wr_en_d     = (a_regnum_i != REG_ZERO);
                    wr_regnum_d = a_regnum_i;
                    wr_data_d   = a_data_i;
                end else if (gnt[1]) begin
                    wr_en_d     = (b_regnum_i != REG_ZERO);
                    wr_regnum_d = b_regnum_i;
                    wr_data_d   = b_data_i;
                end
            end
            CLEAR: begin
                wr_en_d     = 1'b1;
                wr_regnum_d = cnt_q;
                wr_data_d   = '0;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_regnum_q <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_regnum_q <= wr_regnum_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign a_ready_o   = gnt[0];
    assign b_ready_o   = gnt[1];
    assign busy_o      = (state_q == CLEAR);
    assign wr_enable_o = wr_en_q;
    assign wr_regnum_o = wr_regnum_q;
    assign wr_data_o   = wr_data_q;
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl with a queue-based reference model.
module tb_regfile_write_ctrl;
    import regfile_pkg::*;

    typedef struct {
        logic              en;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid = 1'b0, b_valid = 1'b0, clear_req = 1'b0;
    logic [ADDR_W-1:0] a_regnum = '0, b_regnum = '0;
    logic [DATA_W-1:0] a_data = '0, b_data = '0;
    logic              a_ready, b_ready, busy, wr_enable;
    logic [ADDR_W-1:0] wr_regnum;
    logic [DATA_W-1:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t              sb_q[$];
    logic [ADDR_W-1:0] m_clear_q[$];
    logic              m_last_b = 1'b1;
    logic [DATA_W-1:0] m_rf [NUM_REGS] = '{default: '0};
    logic [DATA_W-1:0] rf   [NUM_REGS] = '{default: '0};

    always #5 clk = ~clk;

    regfile_write_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .a_valid_i   (a_valid),
        .a_regnum_i  (a_regnum),
        .a_data_i    (a_data),
        .a_ready_o   (a_ready),
        .b_valid_i   (b_valid),
        .b_regnum_i  (b_regnum),
        .b_data_i    (b_data),
        .b_ready_o   (b_ready),
        .clear_req_i (clear_req),
        .busy_o      (busy),
        .wr_enable_o (wr_enable),
        .wr_regnum_o (wr_regnum),
        .wr_data_o   (wr_data)
    );

    // Stand-in register file, deliberately not hardwiring register 0.
    always @(posedge clk) if (wr_enable) rf[wr_regnum] <= wr_data;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int r = 0; r < NUM_REGS; r++)
            chk($sformatf("%s rf[%0d]", tag, r), rf[r], m_rf[r]);
    endtask

    // Called at a negedge; drives one cycle, checks readies, pushes the expected write.
    task automatic drive_cycle(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                               input logic bv, input logic [ADDR_W-1:0] br, input logic [DATA_W-1:0] bd,
                               input logic clr, output logic ga, output logic gb);
        exp_t e;
        logic busy_exp;
        a_valid = av; a_regnum = ar; a_data = ad;
        b_valid = bv; b_regnum = br; b_data = bd;
        clear_req = clr;
        #1;
        ga = 1'b0; gb = 1'b0;
        e.en = 1'b0; e.r = '0; e.d = '0;
        busy_exp = (m_clear_q.size() != 0);
        if (busy_exp) begin
            e.en = 1'b1;
            e.r  = m_clear_q.pop_front();
        end else if (clr) begin
            for (int r = 1; r < NUM_REGS; r++) m_clear_q.push_back(ADDR_W'(r));
        end else begin
            if (av && bv) begin
                ga = m_last_b;
                gb = !m_last_b;
            end else begin
                ga = av;
                gb = bv;
            end
            if (ga) begin
                e.en = (ar != 0); e.r = ar; e.d = ad; m_last_b = 1'b0;
            end else if (gb) begin
                e.en = (br != 0); e.r = br; e.d = bd; m_last_b = 1'b1;
            end
        end
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        chk("busy", busy, busy_exp);
        @(posedge clk);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic ga, gb;
        for (int i = 0; i < n; i++) drive_cycle(0, '0, '0, 0, '0, '0, 0, ga, gb);
    endtask

    // Monitor: compares wr_* against the scoreboard and commits writes to the model
    // register file one edge later, when the real register file captures them.
    initial begin
        exp_t              e;
        logic              pend = 1'b0;
        logic [ADDR_W-1:0] pend_r = '0;
        logic [DATA_W-1:0] pend_d = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                continue;
            end
            if (pend) m_rf[pend_r] = pend_d;
            pend = 1'b0;
            #1;
            if (!rst_n) continue;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wr_enable", wr_enable, e.en);
                if (e.en) begin
                    chk("wr_regnum", wr_regnum, e.r);
                    chk("wr_data", wr_data, e.d);
                    pend = 1'b1; pend_r = e.r; pend_d = e.d;
                end
            end
        end
    end

    initial begin
        logic              ga, gb, pa, pb;
        logic [ADDR_W-1:0] par, pbr;
        logic [DATA_W-1:0] pad, pbd;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst wr_enable", wr_enable, 0);
        chk("rst wr_regnum", wr_regnum, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: fresh arbiter, A wins the first tie, then alternates.
        for (int i = 0; i < 4; i++) drive_cycle(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, ga, gb);
        idle(2);
        chk("contention rf[3]", rf[3], 32'h11);
        chk("contention rf[4]", rf[4], 32'h22);

        drive_cycle(1, 5'd2, 32'd88, 0, '0, '0, 0, ga, gb);
        idle(2);
        chk("single rf[2]", rf[2], 32'd88);

        drive_cycle(0, '0, '0, 1, 5'd0, 32'hFFFF, 0, ga, gb);
        idle(2);
        chk("zero rf[0]", rf[0], 32'd0);

        // Clear with A held valid throughout; clear_req re-pulsed during the sweep is ignored.
        drive_cycle(1, 5'd5, 32'hAAAA5555, 0, '0, '0, 0, ga, gb);
        drive_cycle(0, '0, '0, 1, 5'd31, 32'h31313131, 0, ga, gb);
        idle(2);
        chk("preload rf[5]", rf[5], 32'hAAAA5555);
        drive_cycle(1, 5'd7, 32'h77, 0, '0, '0, 1, ga, gb);
        for (int i = 0; i < 31; i++) drive_cycle(1, 5'd7, 32'h77, 0, '0, '0, (i % 3 == 0), ga, gb);
        drive_cycle(1, 5'd7, 32'h77, 0, '0, '0, 0, ga, gb);
        idle(2);
        chk("clear rf[5]", rf[5], 32'd0);
        chk("clear rf[31]", rf[31], 32'd0);
        chk("post-clear rf[7]", rf[7], 32'h77);
        check_rf("clear");

        // Reset in the middle of a sweep, after registers 1..10 have landed.
        drive_cycle(1, 5'd20, 32'h2020, 0, '0, '0, 0, ga, gb);
        drive_cycle(0, '0, '0, 1, 5'd31, 32'hBEEF, 0, ga, gb);
        drive_cycle(0, '0, '0, 1, 5'd11, 32'h1111, 0, ga, gb);
        drive_cycle(0, '0, '0, 0, '0, '0, 1, ga, gb);
        for (int i = 0; i < 11; i++) drive_cycle(1, 5'd2, 32'd89, 0, '0, '0, 0, ga, gb);
        rst_n = 1'b0;
        #1;
        chk("midrst wr_enable", wr_enable, 0);
        chk("midrst wr_regnum", wr_regnum, 0);
        chk("midrst wr_data", wr_data, 0);
        chk("midrst busy", busy, 0);
        chk("midrst a_ready", a_ready, 0);
        @(negedge clk);
        sb_q.delete();
        m_clear_q.delete();
        m_last_b = 1'b1;
        rst_n = 1'b1;
        drive_cycle(1, 5'd2, 32'd89, 0, '0, '0, 0, ga, gb);
        idle(2);
        chk("midrst rf[2]", rf[2], 32'd89);
        chk("midrst rf[10]", rf[10], 32'd0);
        chk("midrst rf[11]", rf[11], 32'h1111);
        chk("midrst rf[20]", rf[20], 32'h2020);
        chk("midrst rf[31]", rf[31], 32'hBEEF);
        check_rf("midrst");

        // Random traffic; requests are held until the model grants them.
        pa = 1'b0; pb = 1'b0;
        par = '0; pbr = '0; pad = '0; pbd = '0;
        for (int c = 0; c < 500; c++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1'b1; par = ADDR_W'($urandom); pad = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1; pbr = ADDR_W'($urandom); pbd = $urandom;
            end
            drive_cycle(pa, par, pad, pb, pbr, pbd, ($urandom_range(0, 59) == 0), ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        idle(40);
        check_rf("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
